mult_seq_signed: RTL and testbench



---
 rtl/mult_seq_signed_if.sv | 28 ++
 rtl/mult_seq_signed.sv | 93 +++++++++
 tb/tb_mult_seq_signed.sv | 175 +++++++++++++++++
 3 files changed

// File: rtl/mult_seq_signed_if.sv
// Handshake bundle for mult_seq_signed.
//   start     : request a multiply (master -> slave), sampled only while idle
//   in_signed : 1 = two's-complement operands, 0 = unsigned
//   x, y      : multiplicand / multiplier, WIDTH bits each
//   busy      : high while the multiplier iterates (slave -> master)
//   done      : one-cycle pulse, prod updated this cycle
//   prod      : full 2*WIDTH-bit product, held until next completion or reset
interface mult_seq_signed_if #(
  parameter int unsigned WIDTH = 8
) ();
  logic                   start;
  logic                   in_signed;
  logic [WIDTH-1:0]       x;
  logic [WIDTH-1:0]       y;
  logic                   busy;
  logic                   done;
  logic [2*WIDTH-1:0]     prod;

  modport master (
    output start, in_signed, x, y,
    input  busy, done, prod
  );

  modport slave (
    input  start, in_signed, x, y,
    output busy, done, prod
  );
endinterface

// File: rtl/mult_seq_signed.sv
// Sequential shift-add multiplier, full 2*WIDTH-bit product, signed or unsigned per operation.
// One shift-add step per cycle over WIDTH cycles; start/busy/done handshake.
// Ports:
//   clk : rising-edge clock
//   rst : synchronous active-high reset
//   bus : mult_seq_signed_if slave (start, in_signed, x, y in; busy, done, prod out)
// WIDTH must match the interface instance's WIDTH (legal range 2..32).
module mult_seq_signed #(
  parameter int unsigned WIDTH = 8
) (
  input logic               clk,
  input logic               rst,
  mult_seq_signed_if.slave  bus
);

  localparam int unsigned PW   = 2 * WIDTH;
  localparam int unsigned CntW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [0:0] {StIdle, StRun} state_e;

  state_e           state_q;
  logic [CntW-1:0]  cnt_q;
  logic [PW-1:0]    acc_q;
  logic [PW-1:0]    mcand_q;   // extended multiplicand, shifted left once per step
  logic [WIDTH-1:0] mplier_q;  // multiplier, shifted right so bit 0 is the current bit
  logic             sgn_q;
  logic             busy_q;
  logic             done_q;
  logic [PW-1:0]    prod_q;

  logic             last;
  logic [PW-1:0]    term;
  logic [PW-1:0]    acc_next;

  always_comb begin
    last = (cnt_q == CntW'(WIDTH - 1));
    term = mplier_q[0] ? mcand_q : '0;
    // In signed mode the multiplier MSB carries negative weight.
    if (sgn_q && last) begin
      acc_next = acc_q - term;
    end else begin
      acc_next = acc_q + term;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= StIdle;
      cnt_q    <= '0;
      acc_q    <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
      sgn_q    <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      prod_q   <= '0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        StIdle: begin
          if (bus.start) begin
            mcand_q  <= bus.in_signed ? {{WIDTH{bus.x[WIDTH-1]}}, bus.x}
                                      : {{WIDTH{1'b0}}, bus.x};
            mplier_q <= bus.y;
            sgn_q    <= bus.in_signed;
            acc_q    <= '0;
            cnt_q    <= '0;
            busy_q   <= 1'b1;
            state_q  <= StRun;
          end
        end
        StRun: begin
          acc_q    <= acc_next;
          mcand_q  <= mcand_q << 1;
          mplier_q <= mplier_q >> 1;
          cnt_q    <= cnt_q + 1'b1;
          if (last) begin
            prod_q  <= acc_next;
            done_q  <= 1'b1;
            busy_q  <= 1'b0;
            state_q <= StIdle;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign bus.busy = busy_q;
  assign bus.done = done_q;
  assign bus.prod = prod_q;

endmodule

// File: tb/tb_mult_seq_signed.sv
module tb_mult_seq_signed;

  logic clk;
  logic rst;

  mult_seq_signed_if #(.WIDTH(4)) m4 ();
  mult_seq_signed_if #(.WIDTH(8)) m8 ();

  mult_seq_signed #(.WIDTH(4)) u_dut4 (.clk(clk), .rst(rst), .bus(m4));
  mult_seq_signed #(.WIDTH(8)) u_dut8 (.clk(clk), .rst(rst), .bus(m8));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  logic [7:0]  q4[$];
  logic [15:0] q8[$];
  logic [15:0] last8 = '0;

  function automatic logic [7:0] ref4(input logic s, input logic [3:0] a, input logic [3:0] b);
    logic [7:0] ea, eb;
    ea = s ? {{4{a[3]}}, a} : {4'h0, a};
    eb = s ? {{4{b[3]}}, b} : {4'h0, b};
    return ea * eb;
  endfunction

  function automatic logic [15:0] ref8(input logic s, input logic [7:0] a, input logic [7:0] b);
    logic [15:0] ea, eb;
    ea = s ? {{8{a[7]}}, a} : {8'h00, a};
    eb = s ? {{8{b[7]}}, b} : {8'h00, b};
    return ea * eb;
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Scoreboard monitors: every done pops one expected product.
  always @(negedge clk) begin
    if (m4.done) begin
      chk("done4_expected", (q4.size() != 0), 1);
      chk("busy_with_done4", m4.busy, 0);
      if (q4.size() != 0) chk("prod4", m4.prod, q4.pop_front());
    end
    if (m8.done) begin
      chk("done8_expected", (q8.size() != 0), 1);
      chk("busy_with_done8", m8.busy, 0);
      if (q8.size() != 0) chk("prod8", m8.prod, q8.pop_front());
    end
  end

  // Called at a negedge; returns at the negedge of the done cycle.
  task automatic op4(input logic s, input logic [3:0] a, input logic [3:0] b);
    int lat;
    m4.start = 1'b1; m4.in_signed = s; m4.x = a; m4.y = b;
    q4.push_back(ref4(s, a, b));
    @(posedge clk); #1;
    m4.start = 1'b0;
    lat = 0;
    for (int i = 1; i <= 30; i++) begin
      @(negedge clk);
      if (m4.done) begin lat = i; break; end
    end
    chk("latency4", lat, 5);
  endtask

  // hold=1 keeps start high and scrambles operands for the whole run.
  task automatic op8(input logic s, input logic [7:0] a, input logic [7:0] b, input bit hold);
    int lat;
    logic [15:0] e;
    e = ref8(s, a, b);
    m8.start = 1'b1; m8.in_signed = s; m8.x = a; m8.y = b;
    q8.push_back(e);
    @(posedge clk); #1;
    if (hold) begin
      m8.x = 8'd9; m8.y = 8'd100; m8.in_signed = ~s;
    end else begin
      m8.start = 1'b0;
    end
    lat = 0;
    for (int i = 1; i <= 40; i++) begin
      @(negedge clk);
      if (m8.done) begin lat = i; break; end
      chk("busy_run8", m8.busy, 1);
      chk("prod_held8", m8.prod, last8);
      if (hold) begin
        m8.x = 8'($urandom); m8.y = 8'($urandom); m8.in_signed = 1'($urandom);
      end
    end
    m8.start = 1'b0;
    chk("latency8", lat, 9);
    last8 = e;
  endtask

  initial begin
    rst = 1'b1;
    m4.start = 1'b0; m4.in_signed = 1'b0; m4.x = '0; m4.y = '0;
    m8.start = 1'b1; m8.in_signed = 1'b0; m8.x = 8'd3; m8.y = 8'd3;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_busy4", m4.busy, 0);
    chk("rst_done4", m4.done, 0);
    chk("rst_prod4", m4.prod, 0);
    chk("rst_busy8", m8.busy, 0);
    chk("rst_done8", m8.done, 0);
    chk("rst_prod8", m8.prod, 0);
    rst = 1'b0;
    m8.start = 1'b0;
    @(negedge clk);
    chk("idle_busy8", m8.busy, 0);

    // Exhaustive WIDTH=4, both modes.
    for (int s = 0; s < 2; s++)
      for (int a = 0; a < 16; a++)
        for (int b = 0; b < 16; b++)
          op4(1'(s), 4'(a), 4'(b));

    // WIDTH=8 corners.
    op8(1'b1, 8'h80, 8'h80, 1'b0);
    op8(1'b1, 8'hFF, 8'h01, 1'b0);
    op8(1'b0, 8'hFF, 8'hFF, 1'b0);
    op8(1'b1, 8'h00, 8'h80, 1'b0);
    op8(1'b0, 8'h00, 8'h80, 1'b0);

    // Start held high with changing operands during RUN.
    op8(1'b0, 8'd3, 8'd5, 1'b1);
    repeat (12) @(negedge clk);
    chk("hold_prod8", m8.prod, 16'd15);
    chk("hold_idle8", m8.busy, 0);

    // Back-to-back: second start lands in the done cycle of the first.
    op8(1'b1, 8'd7, 8'd9, 1'b0);
    op8(1'b1, 8'hFE, 8'd3, 1'b0);

    // Reset at iteration 3 of 8, with a start sampled on the reset edge.
    m8.start = 1'b1; m8.in_signed = 1'b0; m8.x = 8'd11; m8.y = 8'd13;
    @(posedge clk); #1;
    m8.start = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    m8.start = 1'b1; m8.x = 8'd21; m8.y = 8'd22;
    @(negedge clk);
    chk("midrst_busy8", m8.busy, 0);
    chk("midrst_done8", m8.done, 0);
    chk("midrst_prod8", m8.prod, 0);
    rst = 1'b0;
    m8.start = 1'b0;
    last8 = '0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      chk("postrst_busy8", m8.busy, 0);
    end

    // Randomized WIDTH=8 operations with random gaps.
    for (int n = 0; n < 300; n++) begin
      repeat ($urandom_range(0, 3)) @(negedge clk);
      op8(1'($urandom), 8'($urandom), 8'($urandom), 1'b0);
    end

    repeat (20) @(negedge clk);
    chk("q4_drained", q4.size(), 0);
    chk("q8_drained", q8.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
